// File: rtl/pos_sensor_filter.sv
// Sensor conditioning ahead of Top: synchronizes detect/pos, qualifies them with a stability
// window, and reports a clean level, a latched position, a hit pulse and a glitch count.
module pos_sensor_filter #(
  parameter int unsigned STABLE_CYCLES = 250000,
  parameter int unsigned POS_W         = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_detect,
  input  logic [POS_W-1:0] i_pos,
  input  logic             i_clr,
  output logic             o_detect,
  output logic [POS_W-1:0] o_pos,
  output logic             o_hit,
  output logic             o_busy,
  output logic [7:0]       o_glitch_cnt
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StQual, StLocked, StRelease} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]   ref_pos_q, ref_pos_d;
  logic               det_q, det_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               hit_q, hit_d;
  logic [7:0]         glitch_q, glitch_d;

  logic               det_meta, det_sync;
  logic [POS_W-1:0]   pos_meta, pos_sync;

  // Two-flop synchronizers; deliberately untouched by i_clr.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      det_meta <= 1'b0;
      det_sync <= 1'b0;
      pos_meta <= '0;
      pos_sync <= '0;
    end else begin
      det_meta <= i_detect;
      det_sync <= det_meta;
      pos_meta <= i_pos;
      pos_sync <= pos_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ref_pos_q <= '0;
      det_q     <= 1'b0;
      pos_q     <= '0;
      hit_q     <= 1'b0;
      glitch_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_pos_q <= ref_pos_d;
      det_q     <= det_d;
      pos_q     <= pos_d;
      hit_q     <= hit_d;
      glitch_q  <= glitch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_pos_d = ref_pos_q;
    det_d     = det_q;
    pos_d     = pos_q;
    hit_d     = 1'b0;
    glitch_d  = glitch_q;
    if (i_clr) begin
      state_d  = StIdle;
      cnt_d    = '0;
      det_d    = 1'b0;
      pos_d    = '0;
      glitch_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (det_sync) begin
            state_d   = StQual;
            cnt_d     = CntOne;
            ref_pos_d = pos_sync;
          end
        end
        StQual: begin
          // A detect drop outranks a simultaneous position change.
          if (!det_sync) begin
            state_d = StIdle;
            if (glitch_q != 8'hff) glitch_d = glitch_q + 8'd1;
          end else if (pos_sync != ref_pos_q) begin
            cnt_d     = CntOne;
            ref_pos_d = pos_sync;
          end else if (cnt_q == CntLast) begin
            state_d = StLocked;
            pos_d   = ref_pos_q;
            det_d   = 1'b1;
            hit_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StLocked: begin
          if (!det_sync) begin
            state_d = StRelease;
            cnt_d   = CntOne;
          end
        end
        StRelease: begin
          if (det_sync) begin
            state_d = StLocked;
          end else if (cnt_q == CntLast) begin
            state_d = StIdle;
            det_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign o_detect     = det_q;
  assign o_pos        = pos_q;
  assign o_hit        = hit_q;
  assign o_busy       = (state_q == StQual) || (state_q == StRelease);
  assign o_glitch_cnt = glitch_q;

endmodule

// File: tb/tb_pos_sensor_filter.sv
// Bench for pos_sensor_filter: directed scenarios plus random stimulus against a timestamp-based
// reference model of the qualification rules.
module tb_pos_sensor_filter;

  localparam int unsigned S  = 4;
  localparam int unsigned PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          det_in;
  logic [PW-1:0] pos_in;
  logic          clr;
  logic          o_detect;
  logic [PW-1:0] o_pos;
  logic          o_hit;
  logic          o_busy;
  logic [7:0]    o_glitch_cnt;

  pos_sensor_filter #(.STABLE_CYCLES(S), .POS_W(PW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_detect     (det_in),
    .i_pos        (pos_in),
    .i_clr        (clr),
    .o_detect     (o_detect),
    .o_pos        (o_pos),
    .o_hit        (o_hit),
    .o_busy       (o_busy),
    .o_glitch_cnt (o_glitch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase name, window start edge, and a delay line standing in for the sync.
  localparam int PIdle = 0, PQual = 1, PLocked = 2, PRelease = 3;
  int          m_phase;
  int          m_start;
  int          m_edge;
  bit [PW-1:0] m_ref;
  bit          m_det;
  bit [PW-1:0] m_pos;
  bit          m_hit;
  int          m_glitch;
  bit          hist_det[$];
  bit [PW-1:0] hist_pos[$];

  task automatic model_reset();
    m_phase = PIdle; m_start = 0; m_edge = 0; m_ref = '0;
    m_det = 0; m_pos = '0; m_hit = 0; m_glitch = 0;
    hist_det.delete(); hist_pos.delete();
  endtask

  task automatic model_edge(input bit d, input bit [PW-1:0] p, input bit c);
    bit          sd;
    bit [PW-1:0] sp;
    m_edge++;
    // Decisions at this edge see the input sampled two edges earlier.
    sd = (hist_det.size() >= 2) ? hist_det[hist_det.size()-2] : 1'b0;
    sp = (hist_pos.size() >= 2) ? hist_pos[hist_pos.size()-2] : '0;
    hist_det.push_back(d); hist_pos.push_back(p);
    if (hist_det.size() > 2) begin void'(hist_det.pop_front()); void'(hist_pos.pop_front()); end
    m_hit = 0;
    if (c) begin
      m_phase = PIdle; m_det = 0; m_pos = '0; m_glitch = 0;
    end else begin
      case (m_phase)
        PIdle: if (sd) begin m_phase = PQual; m_start = m_edge; m_ref = sp; end
        PQual: begin
          if (!sd) begin
            m_phase = PIdle;
            m_glitch = (m_glitch < 255) ? m_glitch + 1 : 255;
          end else if (sp != m_ref) begin
            m_start = m_edge; m_ref = sp;
          end else if (m_edge - m_start == S - 1) begin
            m_phase = PLocked; m_pos = m_ref; m_det = 1; m_hit = 1;
          end
        end
        PLocked: if (!sd) begin m_phase = PRelease; m_start = m_edge; end
        default: begin
          if (sd) m_phase = PLocked;
          else if (m_edge - m_start == S - 1) begin m_phase = PIdle; m_det = 0; end
        end
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".detect"}, o_detect, m_det);
    check_eq({tag, ".pos"}, o_pos, m_pos);
    check_eq({tag, ".hit"}, o_hit, m_hit);
    check_eq({tag, ".busy"}, o_busy, (m_phase == PQual || m_phase == PRelease));
    check_eq({tag, ".glitch"}, o_glitch_cnt, m_glitch);
  endtask

  // One clock: drive inputs, take the edge, step the model, check 1 ns later.
  task automatic cycle(input bit d, input bit [PW-1:0] p, input bit c, input string tag);
    det_in = d; pos_in = p; clr = c;
    @(posedge clk);
    model_edge(d, p, c);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; det_in = 0; pos_in = '0; clr = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    compare_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    int first;
    int hits;
    logic [7:0] busy_mask;
    bit   d;
    bit   [PW-1:0] p;
    int   hold;

    rst = 1'b1; det_in = 0; pos_in = '0; clr = 0;
    #2;
    do_reset();

    // Scenario 1: hit appears after edge S+2, busy on edges 3..5 only.
    first = -1; busy_mask = '0;
    for (int e = 1; e <= 8; e++) begin
      cycle(1'b1, 3'd5, 1'b0, "s1");
      if (o_hit && first < 0) first = e;
      if (o_busy) busy_mask[e-1] = 1'b1;
    end
    check_eq("s1.hit_edge", first, S + 2);
    check_eq("s1.busy_mask", busy_mask, 8'b0001_1100);
    check_eq("s1.pos", o_pos, 5);
    check_eq("s1.detect", o_detect, 1);

    // Scenario 4: short drop with new pos keeps lock; long drop releases after edge S+2.
    for (int e = 0; e < 2; e++) cycle(1'b0, 3'd5, 1'b0, "s4");
    hits = 0;
    for (int e = 0; e < 10; e++) begin
      cycle(1'b1, 3'd7, 1'b0, "s4");
      if (o_hit) hits++;
    end
    check_eq("s4.no_rehit", hits, 0);
    check_eq("s4.pos_held", o_pos, 5);
    first = -1;
    for (int e = 1; e <= 12; e++) begin
      cycle(1'b0, 3'd7, 1'b0, "s4r");
      if (!o_detect && first < 0) first = e;
    end
    check_eq("s4.release_edge", first, S + 2);

    // Scenario 2: repeated short pulses count glitches and saturate.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      for (int e = 0; e < 3; e++) cycle(1'b1, 3'd1, 1'b0, "s2");
      for (int e = 0; e < 3; e++) cycle(1'b0, 3'd1, 1'b0, "s2");
      if (k == 0) check_eq("s2.first_glitch", o_glitch_cnt, 1);
    end
    check_eq("s2.saturated", o_glitch_cnt, 255);
    check_eq("s2.no_detect", o_detect, 0);

    // Scenario 3: pos change mid-qualification restarts the window.
    do_reset();
    for (int e = 0; e < 3; e++) cycle(1'b1, 3'd2, 1'b0, "s3");
    hits = 0;
    for (int e = 0; e < 10; e++) begin
      cycle(1'b1, 3'd6, 1'b0, "s3");
      if (o_hit) hits++;
    end
    check_eq("s3.one_hit", hits, 1);
    check_eq("s3.pos", o_pos, 6);
    check_eq("s3.glitch", o_glitch_cnt, 0);

    // Scenario 5: clr on the locking edge wins; hit then arrives S+1 edges after (clr edge = 1).
    do_reset();
    for (int e = 1; e <= 5; e++) cycle(1'b1, 3'd4, 1'b0, "s5");
    cycle(1'b1, 3'd4, 1'b1, "s5clr");
    check_eq("s5.clr_hit", o_hit, 0);
    check_eq("s5.clr_detect", o_detect, 0);
    first = -1;
    for (int e = 2; e <= 12; e++) begin
      cycle(1'b1, 3'd4, 1'b0, "s5");
      if (o_hit && first < 0) first = e;
    end
    check_eq("s5.hit_after_clr", first, S + 1);

    // Scenario 6: async reset between edges while locked clears outputs immediately.
    #2 rst = 1'b1;
    #1;
    check_eq("s6.async_detect", o_detect, 0);
    check_eq("s6.async_pos", o_pos, 0);
    check_eq("s6.async_busy", o_busy, 0);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    first = -1;
    for (int e = 1; e <= 8; e++) begin
      cycle(1'b1, 3'd3, 1'b0, "s6");
      if (o_hit && first < 0) first = e;
    end
    check_eq("s6.requal_edge", first, S + 2);

    // Random stimulus with variable hold times, sparse pos changes and rare clears.
    do_reset();
    d = 0; p = '0; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        d = $urandom_range(0, 1);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 9) == 0) p = PW'($urandom);
      cycle(d, p, ($urandom_range(0, 79) == 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
